mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: MEM_LAT, 2, memory read latency in cycles (>=1); STARVE_MAX, 2, consecutive data grants allowed while a fetch waits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 if_req  in  1  fetch port request; if_addr  in  32  fetch address.
REQ-005 if_gnt  out  1  fetch issued this cycle; if_rvalid  out  1  fetch data valid pulse; if_rdata  out  32  fetch data.
REQ-006 dm_req  in  1; dm_we  in  1; dm_addr  in  32; dm_wdata  in  32; dm_be  in  4  data port request, write enable, address, write data, byte enables.
REQ-007 dm_gnt  out  1; dm_rvalid  out  1  completion pulse (read or write); dm_rdata  out  32.
REQ-008 mem_en, mem_we  out  1; mem_addr, mem_wdata  out  32; mem_be  out  4; mem_rdata  in  32  single-port memory interface.
REQ-009 stall_if, stall_mem  out  1  pipeline hold requests for fetch and memory stages.

Function
REQ-010 FSM states SHALL be IDLE and WAIT; at most one transaction outstanding.
REQ-011 Issue SHALL occur only in IDLE when at least one req is high; issue cycle T asserts exactly one gnt and mem_en=1 combinationally, mem_addr/mem_we/mem_wdata/mem_be muxed from the winner (fetch: mem_we=0, mem_be=4'hF, mem_wdata=0).
REQ-012 Outside an issue cycle, mem_en and mem_we SHALL be 0.
REQ-013 Requester SHALL hold req and payload stable until gnt; req high after its own gnt cycle is a new request.
REQ-014 A port with an outstanding transaction SHALL NOT be granted again before its rvalid.
REQ-015 Priority: data port wins when both request, except when dm_streak==STARVE_MAX, then fetch wins.
REQ-016 dm_streak SHALL increment on each data grant with if_req=1, saturate at STARVE_MAX, clear on any fetch grant or on a data grant with if_req=0.
REQ-017 After issue, FSM SHALL stay in WAIT for cycles T+1..T+MEM_LAT; mem_rdata is sampled at end of T+MEM_LAT.
REQ-018 Read completion: x_rdata SHALL register mem_rdata at end of T+MEM_LAT; x_rvalid SHALL pulse high for exactly cycle T+MEM_LAT+1.
REQ-019 Write completion: dm_rvalid SHALL pulse in T+MEM_LAT+1; dm_rdata SHALL hold its previous value.
REQ-020 FSM SHALL return to IDLE in T+MEM_LAT+1; a new issue is allowed in that same cycle (throughput one per MEM_LAT+1 cycles).
REQ-021 stall_if SHALL equal (if_req & ~if_gnt) | if_pend, where if_pend is set at fetch gnt and cleared in the if_rvalid cycle (stall low during rvalid); stall_mem likewise for the data port.
REQ-022 if_rdata/dm_rdata SHALL hold value between completions.

Reset
REQ-023 reset=0 SHALL force IDLE, dm_streak=0, pend flags=0, all gnt/rvalid/stall/mem_en/mem_we=0, rdata outputs=0, asynchronously.
REQ-024 Reset during WAIT SHALL abort the transaction; no rvalid SHALL follow; first edge after release operates from IDLE.

Verification (MEM_LAT=2, STARVE_MAX=2)
REQ-025 reset=0 with all req=1 -> all outputs 0, mem_en=0 throughout.
REQ-026 if_req=1, if_addr=0x00400000 at T, mem_rdata=0x2008000A at T+2 -> if_gnt, mem_en, mem_addr=0x00400000 at T; stall_if=1 T..T+2, 0 at T+3; if_rvalid=1 only at T+3, if_rdata=0x2008000A.
REQ-027 if_req and dm_req (read 0x10010000) both rise at T -> dm_gnt at T, if_gnt at T+3, dm_rvalid at T+3, if_rvalid at T+6.
REQ-028 dm_req and if_req held continuously -> grant order dm, dm, if, dm, dm, if at T, T+3, T+6, ...
REQ-029 dm write addr 0x10010000, wdata 0xDEADBEEF, be 4'hF at T -> mem_we=1, mem_wdata=0xDEADBEEF at T only; dm_rvalid at T+3; dm_rdata unchanged.
REQ-030 reset=0 at T+1 of a fetch, released at T+2 -> no if_rvalid, stall_if=0; fresh if_req granted on first cycle after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates a fetch port and a data port onto one single-port memory, one transaction in flight.
// Latency: grant and memory strobe combinational in the issue cycle; rvalid/rdata registered MEM_LAT+1 cycles later.
// Backpressure: a requester holds req until its gnt; stall_* tell the pipeline to hold while waiting or in flight.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          cur_if;
    logic          cur_we;
    logic          if_pend_q;
    logic          dm_pend_q;

    logic          can_issue;
    logic          starve;
    logic          pick_if;
    logic          pick_dm;

    // Winner selection: data port first unless fetch has been passed over STARVE_MAX times in a row.
    // Gated by reset so nothing is granted or strobed while reset is held.
    always_comb begin
        can_issue = reset && (state == IDLE);
        starve    = (streak == SW'(STARVE_MAX));
        pick_if   = can_issue && if_req && (!dm_req || starve);
        pick_dm   = can_issue && dm_req && !pick_if;
    end

    // Grant, memory strobe and stall outputs; the issuing port counts as pending from its grant cycle.
    always_comb begin
        if_gnt    = pick_if;
        dm_gnt    = pick_dm;
        mem_en    = pick_if || pick_dm;
        mem_we    = pick_dm && dm_we;
        mem_addr  = pick_dm ? dm_addr  : (pick_if ? if_addr : 32'h0);
        mem_wdata = pick_dm ? dm_wdata : 32'h0;
        mem_be    = pick_dm ? dm_be    : (pick_if ? 4'hF : 4'h0);
        stall_if  = reset && ((if_req && !pick_if) || pick_if || if_pend_q);
        stall_mem = reset && ((dm_req && !pick_dm) || pick_dm || dm_pend_q);
    end

    // Transaction FSM: issue in IDLE, count out the memory latency in WAIT, complete and return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            cur_if    <= 1'b0;
            cur_we    <= 1'b0;
            if_pend_q <= 1'b0;
            dm_pend_q <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_if || pick_dm) begin
                        state     <= WAIT;
                        cnt       <= '0;
                        cur_if    <= pick_if;
                        cur_we    <= pick_dm && dm_we;
                        if_pend_q <= pick_if;
                        dm_pend_q <= pick_dm;
                        // Streak counts data grants that made a waiting fetch wait longer.
                        if (pick_if || !if_req) begin
                            streak <= '0;
                        end else if (!starve) begin
                            streak <= streak + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CW'(MEM_LAT - 1)) begin
                        state     <= IDLE;
                        if_pend_q <= 1'b0;
                        dm_pend_q <= 1'b0;
                        if (cur_if) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end else begin
                            dm_rvalid <= 1'b1;
                            // Writes complete without disturbing the last read value.
                            if (!cur_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=2).
// Latency: table vectors check issue-cycle outputs; hand sequences and a random run check completions.
// Backpressure: stimulus holds each request until the expected grant, then may start a new one.
module tb_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    // Control bits in order: if_gnt dm_gnt mem_en mem_we stall_if stall_mem if_rvalid dm_rvalid
    logic [7:0] ctl;
    assign ctl = {if_gnt, dm_gnt, mem_en, mem_we, stall_if, stall_mem, if_rvalid, dm_rvalid};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_in();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_rdata = 0;
    endtask

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  db;
        logic [7:0]  ectl;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [3:0]  ebe;
    } vec_t;

    vec_t vt[6];

    // Reference model state for the random run
    int          done_at, samp_at, free_at, streak;
    bit          own_if, own_we, gi, gd, last_gi, last_gd, out_if, out_dm, e_rvi, e_rvd, e_si, e_sd;
    logic [31:0] cap, m_if, m_dm;

    initial begin
        reset = 0;
        idle_in();

        // ---------------- table: issue-cycle behaviour from a fresh IDLE ----------------
        vt[0] = '{1'b0, 1'b1, 32'h00400000, 1'b1, 1'b1, 32'h10010000, 32'h11111111, 4'hF,
                  8'b0000_0000, 32'h0, 32'h0, 4'h0};
        vt[1] = '{1'b1, 1'b1, 32'h00400000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                  8'b1010_1000, 32'h00400000, 32'h0, 4'hF};
        vt[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10010000, 32'h12345678, 4'h3,
                  8'b0110_0100, 32'h10010000, 32'h12345678, 4'h3};
        vt[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10010004, 32'hDEADBEEF, 4'hF,
                  8'b0111_0100, 32'h10010004, 32'hDEADBEEF, 4'hF};
        vt[4] = '{1'b1, 1'b1, 32'h00400010, 1'b1, 1'b0, 32'h10010008, 32'h0000ABCD, 4'hC,
                  8'b0110_1100, 32'h10010008, 32'h0000ABCD, 4'hC};
        vt[5] = '{1'b1, 1'b0, 32'h00400014, 1'b0, 1'b1, 32'h10010010, 32'h5A5A5A5A, 4'h1,
                  8'b0000_0000, 32'h0, 32'h0, 4'h0};
        for (int i = 0; i < 6; i++) begin
            reset = 0;
            idle_in();
            step();
            reset = vt[i].rst;
            if_req = vt[i].ir; if_addr = vt[i].ia;
            dm_req = vt[i].dr; dm_we = vt[i].dw; dm_addr = vt[i].da; dm_wdata = vt[i].dwd; dm_be = vt[i].db;
            mid();
            chk($sformatf("vec%0d", i), {ctl, mem_addr, mem_wdata, mem_be},
                {vt[i].ectl, vt[i].eaddr, vt[i].ewd, vt[i].ebe});
            step();
        end

        // Reset held with every request up: nothing may come out on any cycle
        reset = 0; if_req = 1; dm_req = 1; dm_we = 1;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk($sformatf("rst_hold%0d", k), {ctl, if_rdata, dm_rdata}, 72'h0);
            step();
        end

        // ---------------- single fetch with latency 2 ----------------
        idle_in();
        step();
        reset = 1;
        step();
        if_req = 1; if_addr = 32'h00400000; mem_rdata = 32'h11111111;
        mid(); chk("fetch_T", {ctl, mem_addr, mem_be}, {8'b1010_1000, 32'h00400000, 4'hF});
        step(); if_req = 0; mem_rdata = 32'h22222222;
        mid(); chk("fetch_T1", ctl, 8'b0000_1000);
        step(); mem_rdata = 32'h2008000A;
        mid(); chk("fetch_T2", ctl, 8'b0000_1000);
        step(); mem_rdata = 32'h33333333;
        mid(); chk("fetch_T3", {ctl, if_rdata}, {8'b0000_0010, 32'h2008000A});
        step();
        mid(); chk("fetch_T4", {ctl, if_rdata}, {8'b0000_0000, 32'h2008000A});

        // ---------------- simultaneous fetch and data read ----------------
        step();
        if_req = 1; if_addr = 32'h00400004;
        dm_req = 1; dm_we = 0; dm_addr = 32'h10010000; dm_be = 4'hF;
        mid(); chk("both_T", {if_gnt, dm_gnt, mem_addr}, {2'b01, 32'h10010000});
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) dm_req = 0;
            if (k == 4) if_req = 0;
            mem_rdata = (k == 2) ? 32'hCAFEF00D : ((k == 5) ? 32'h0BADF00D : $urandom);
            mid();
            chk($sformatf("both_T%0d", k), {if_gnt, dm_gnt, if_rvalid, dm_rvalid},
                {(k == 3), 1'b0, (k == 6), (k == 3)});
        end
        chk("both_rdata", {if_rdata, dm_rdata}, {32'h0BADF00D, 32'hCAFEF00D});

        // ---------------- data write leaves dm_rdata untouched ----------------
        step();
        dm_req = 1; dm_we = 1; dm_addr = 32'h10010000; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
        mid(); chk("wr_T", {dm_gnt, mem_en, mem_we, mem_wdata, mem_addr}, {3'b111, 32'hDEADBEEF, 32'h10010000});
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) dm_req = 0;
            mem_rdata = $urandom;
            mid();
            chk($sformatf("wr_T%0d", k), {mem_en, mem_we, dm_rvalid, dm_rdata},
                {2'b00, (k == 3), 32'hCAFEF00D});
        end

        // ---------------- reset aborts an in-flight fetch ----------------
        step();
        if_req = 1; if_addr = 32'h00400008; dm_we = 0;
        mid(); chk("abort_T", if_gnt, 1'b1);
        step(); if_req = 0; reset = 0;
        mid(); chk("abort_T1", {ctl, if_rdata, dm_rdata}, 72'h0);
        step(); reset = 1;
        mid(); chk("abort_T2", ctl, 8'h00);
        step(); if_req = 1; if_addr = 32'h0040000C;
        mid(); chk("abort_T3", {ctl, mem_addr}, {8'b1010_1000, 32'h0040000C});
        step(); if_req = 0;
        mid(); chk("abort_T4", {if_rvalid, stall_if}, 2'b01);
        step(); mem_rdata = 32'h5555AAAA;
        mid(); chk("abort_T5", {if_rvalid, stall_if}, 2'b01);
        step(); mem_rdata = 32'h0;
        mid(); chk("abort_T6", {if_rvalid, stall_if, if_rdata}, {2'b10, 32'h5555AAAA});

        // ---------------- both held continuously: dm, dm, if repeating every 3 cycles ----------------
        reset = 0; idle_in();
        step();
        reset = 1;
        if_req = 1; if_addr = 32'h00400020; dm_req = 1; dm_we = 0; dm_addr = 32'h10010020; dm_be = 4'hF;
        for (int k = 0; k < 18; k++) begin
            mid();
            chk($sformatf("starve%0d", k), {if_gnt, dm_gnt},
                (k % 3 != 0) ? 2'b00 : (((k / 3) % 3 == 2) ? 2'b10 : 2'b01));
            step();
        end

        // ---------------- random traffic against a transaction-level model ----------------
        reset = 0; idle_in();
        step();
        reset = 1;
        done_at = -1; samp_at = -1; free_at = 0; streak = 0;
        own_if = 0; own_we = 0; last_gi = 0; last_gd = 0; cap = 0; m_if = 0; m_dm = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || last_gi) begin
                if_req = ($urandom_range(0, 99) < 55); if_addr = $urandom;
            end
            if (!dm_req || last_gd) begin
                dm_req = ($urandom_range(0, 99) < 55); dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
            end
            mem_rdata = $urandom;
            mid();
            e_rvi = 0; e_rvd = 0;
            if (c == done_at) begin
                if (own_if) begin e_rvi = 1; m_if = cap; end
                else begin e_rvd = 1; if (!own_we) m_dm = cap; end
            end
            if (c == samp_at) cap = mem_rdata;
            out_if = (c < done_at) && own_if;
            out_dm = (c < done_at) && !own_if;
            gi = (c >= free_at) && if_req && (!dm_req || streak == SMAX);
            gd = (c >= free_at) && dm_req && !gi;
            e_si = (if_req && !gi) || gi || out_if;
            e_sd = (dm_req && !gd) || gd || out_dm;
            chk("rnd_ctl", ctl, {gi, gd, gi | gd, gd & dm_we, e_si, e_sd, e_rvi, e_rvd});
            if (gi || gd) begin
                chk("rnd_bus", {mem_addr, mem_wdata, mem_be},
                    gi ? {if_addr, 32'h0, 4'hF} : {dm_addr, dm_wdata, dm_be});
                own_if  = gi;
                own_we  = gd && dm_we;
                samp_at = c + LAT;
                done_at = c + LAT + 1;
                free_at = done_at;
                if (gi || !if_req) streak = 0;
                else if (streak < SMAX) streak++;
            end
            chk("rnd_rdata", {if_rdata, dm_rdata}, {m_if, m_dm});
            last_gi = gi; last_gd = gd;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
